// File: rtl/xillybus_stream_pkg.sv
// rtl/xillybus_stream_pkg.sv - shared state type, pointer-width helper and legal word widths
package xillybus_stream_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_DRAIN  = 2'd2,
    ST_EOF    = 2'd3
  } state_t;

  localparam int LEGAL_DATA_W [3] = '{8, 16, 32};

  function automatic int ptr_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  function automatic bit data_w_legal(input int w);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if (LEGAL_DATA_W[i] == w) ok = 1'b1;
    end
    return ok;
  endfunction

endpackage

// File: rtl/xillybus_stream_ram.sv
// rtl/xillybus_stream_ram.sv - simple dual-port RAM, synchronous write, registered read
module xillybus_stream_ram
  import xillybus_stream_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 512,
  parameter int AW     = ptr_width(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [AW-1:0]     wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  input  logic [AW-1:0]     rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  // Only the output register is reset; array contents are left as-is.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)        rd_data <= '0;
    else if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/xillybus_stream_fifo.sv
// rtl/xillybus_stream_fifo.sv - Xillybus-style stream FIFO with open/EOF tracking
// Optional registered irq output enabled by XILLYBUS_STREAM_IRQ_EN.
module xillybus_stream_fifo
  import xillybus_stream_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int DEPTH      = 512,
  parameter int IRQ_THRESH = DEPTH / 2
) (
  input  logic                   bus_clk,
  input  logic                   bus_rst,
  input  logic                   user_w_wren,
  input  logic [DATA_W-1:0]      user_w_data,
  output logic                   user_w_full,
  input  logic                   user_w_open,
  input  logic                   user_r_rden,
  output logic [DATA_W-1:0]      user_r_data,
  output logic                   user_r_empty,
  output logic                   user_r_eof,
  input  logic                   user_r_open,
  output logic [$clog2(DEPTH):0] fill_level,
  output logic                   overflow_err,
  output logic                   irq
);

  localparam int AW = ptr_width(DEPTH);
  localparam int FW = $clog2(DEPTH) + 1;

  logic          rst_q;
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [FW-1:0] fill_upd;
  logic          w_open_q, r_open_q;
  logic          wr_acc, rd_acc, flush, w_rise, w_fall;
  state_t        state, state_nxt;

  // Assertion passes straight through; release is retimed so logic wakes on the second edge.
  always_ff @(posedge bus_clk or posedge bus_rst) begin
    if (bus_rst) rst_q <= 1'b1;
    else         rst_q <= 1'b0;
  end

  assign flush  = (state == ST_IDLE) && !user_w_open && !user_r_open && !w_open_q && !r_open_q;
  assign wr_acc = user_w_wren && !user_w_full && !flush;
  assign rd_acc = user_r_rden && !user_r_empty && !flush;
  assign w_rise = user_w_open && !w_open_q;
  assign w_fall = !user_w_open && w_open_q;

  always_comb begin
    fill_upd = fill_level + FW'(wr_acc) - FW'(rd_acc);
    if (flush) fill_upd = '0;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:   if (w_rise) state_nxt = ST_ACTIVE;
      ST_ACTIVE: if (w_fall) state_nxt = (fill_level != '0) ? ST_DRAIN : ST_EOF;
      ST_DRAIN: begin
        if (w_rise)                 state_nxt = ST_ACTIVE;
        else if (fill_level == '0)  state_nxt = ST_EOF;
      end
      ST_EOF: begin
        if (w_rise)            state_nxt = ST_ACTIVE;
        else if (!user_r_open) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge bus_clk or posedge rst_q) begin
    if (rst_q) begin
      state    <= ST_IDLE;
      w_open_q <= 1'b0;
      r_open_q <= 1'b0;
    end else begin
      state    <= state_nxt;
      w_open_q <= user_w_open;
      r_open_q <= user_r_open;
    end
  end

  always_ff @(posedge bus_clk or posedge rst_q) begin
    if (rst_q) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      fill_level   <= '0;
      user_w_full  <= 1'b0;
      user_r_empty <= 1'b1;
      overflow_err <= 1'b0;
    end else if (flush) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      fill_level   <= '0;
      user_w_full  <= 1'b0;
      user_r_empty <= 1'b1;
      overflow_err <= 1'b0;
    end else begin
      if (wr_acc) wr_ptr <= wr_ptr + AW'(1);
      if (rd_acc) rd_ptr <= rd_ptr + AW'(1);
      fill_level   <= fill_upd;
      user_w_full  <= (fill_upd == FW'(DEPTH));
      user_r_empty <= (fill_upd == '0);
      if (user_w_wren && user_w_full) overflow_err <= 1'b1;
    end
  end

  assign user_r_eof = (state == ST_EOF) && user_r_empty;

`ifdef XILLYBUS_STREAM_IRQ_EN
  always_ff @(posedge bus_clk or posedge rst_q) begin
    if (rst_q) irq <= 1'b0;
    else       irq <= (fill_upd >= FW'(IRQ_THRESH)) || (state_nxt == ST_EOF);
  end
`else
  assign irq = 1'b0;
`endif

  xillybus_stream_ram #(
    .DATA_W(DATA_W),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_ram (
    .clk    (bus_clk),
    .rst    (rst_q),
    .wr_en  (wr_acc),
    .wr_addr(wr_ptr),
    .wr_data(user_w_data),
    .rd_en  (rd_acc),
    .rd_addr(rd_ptr),
    .rd_data(user_r_data)
  );

endmodule
